// File: rtl/frame_renderer_if.sv
// Handshake and pixel bus between the game controller and the frame renderer.
// The controller owns the master side; the renderer owns the slave side.
interface frame_renderer_if;
  logic       start;
  logic [6:0] bird_y;
  logic [7:0] wall_x;
  logic [6:0] gap_y;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output start, bird_y, wall_x, gap_y,
    input  x_out, y_out, colour_out, plot, busy, done
  );

  modport slave (
    input  start, bird_y, wall_x, gap_y,
    output x_out, y_out, colour_out, plot, busy, done
  );
endinterface

// File: rtl/frame_renderer.sv
// Frame renderer: erases the bird and wall at their previous positions, then
// redraws them at the new positions, one pixel per clock toward vga_adapter.
//
// state        | meaning
// -------------+--------------------------------------------------------------
// S_IDLE       | waiting for start; latches the new positions when it arrives
// S_ERASE_BIRD | scanning the previous bird square in background colour
// S_ERASE_WALL | scanning the previous wall column in background colour
// S_DRAW_WALL  | scanning the new wall column, gap rows suppressed
// S_DRAW_BIRD  | scanning the new bird square
// S_DONE       | one-cycle done pulse; new positions become the previous ones
module frame_renderer #(
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120,
  parameter int         BIRD_X      = 20,
  parameter int         BIRD_SIZE   = 4,
  parameter int         WALL_W      = 8,
  parameter int         GAP_H       = 40,
  parameter logic [2:0] BG_COLOUR   = 3'b000,
  parameter logic [2:0] BIRD_COLOUR = 3'b110,
  parameter logic [2:0] WALL_COLOUR = 3'b010
) (
  input  logic            clk,
  input  logic            resetn,
  frame_renderer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE_BIRD,
    S_ERASE_WALL,
    S_DRAW_WALL,
    S_DRAW_BIRD,
    S_DONE
  } state_t;

  localparam logic [6:0] BIRD_LAST   = 7'(BIRD_SIZE - 1);
  localparam logic [6:0] WALL_X_LAST = 7'(WALL_W - 1);
  localparam logic [6:0] WALL_Y_LAST = 7'(SCREEN_H - 1);
  localparam logic [8:0] BIRD_X9     = 9'(BIRD_X);
  localparam logic [8:0] SCREEN_W9   = 9'(SCREEN_W);
  localparam logic [8:0] SCREEN_H9   = 9'(SCREEN_H);
  localparam logic [8:0] GAP_H9      = 9'(GAP_H);

  state_t     state, state_nxt, state_follow;
  logic [6:0] cx, cy, cx_nxt, cy_nxt;
  logic [6:0] last_w, last_h;

  logic       take_start;
  logic [6:0] new_bird_y, new_gap_y, new_bird_y_nxt, new_gap_y_nxt;
  logic [7:0] new_wall_x, new_wall_x_nxt;
  logic [6:0] prev_bird_y, prev_gap_y;
  logic [7:0] prev_wall_x;
  logic       prev_valid;

  logic       erase;
  logic [6:0] src_bird_y, src_gap_y;
  logic [7:0] src_wall_x;
  logic       pixel_state, in_gap, pix_plot;
  logic [8:0] pix_x9, pix_y9, gap_lo9;
  logic [2:0] pix_col;

  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] col_q;
  logic       plot_q, busy_q, done_q;

  // The new-position registers are loaded in the same edge that leaves IDLE,
  // so the first drawn pixel must see the bus values rather than the registers.
  assign take_start     = (state == S_IDLE) && bus.start;
  assign new_bird_y_nxt = take_start ? bus.bird_y : new_bird_y;
  assign new_wall_x_nxt = take_start ? bus.wall_x : new_wall_x;
  assign new_gap_y_nxt  = take_start ? bus.gap_y  : new_gap_y;

  // State register and scan counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      cx    <= '0;
      cy    <= '0;
    end else begin
      state <= state_nxt;
      cx    <= cx_nxt;
      cy    <= cy_nxt;
    end
  end

  // Successor of each pixel state once its last pixel has been emitted.
  always_comb begin
    state_follow = S_IDLE;
    case (state)
      S_ERASE_BIRD: state_follow = S_ERASE_WALL;
      S_ERASE_WALL: state_follow = S_DRAW_WALL;
      S_DRAW_WALL:  state_follow = S_DRAW_BIRD;
      S_DRAW_BIRD:  state_follow = S_DONE;
      default:      state_follow = S_IDLE;
    endcase
  end

  // Next-state logic and raster scan: cx is the inner counter, cy the outer.
  always_comb begin
    state_nxt = state;
    cx_nxt    = cx;
    cy_nxt    = cy;
    last_w    = '0;
    last_h    = '0;
    case (state)
      S_ERASE_BIRD, S_DRAW_BIRD: begin
        last_w = BIRD_LAST;
        last_h = BIRD_LAST;
      end
      S_ERASE_WALL, S_DRAW_WALL: begin
        last_w = WALL_X_LAST;
        last_h = WALL_Y_LAST;
      end
      default: ;
    endcase
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = prev_valid ? S_ERASE_BIRD : S_DRAW_WALL;
          cx_nxt    = '0;
          cy_nxt    = '0;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: begin
        if (cx == last_w) begin
          cx_nxt = '0;
          if (cy == last_h) begin
            cy_nxt    = '0;
            state_nxt = state_follow;
          end else begin
            cy_nxt = cy + 7'd1;
          end
        end else begin
          cx_nxt = cx + 7'd1;
        end
      end
    endcase
  end

  assign erase      = (state_nxt == S_ERASE_BIRD) || (state_nxt == S_ERASE_WALL);
  assign src_bird_y = erase ? prev_bird_y : new_bird_y_nxt;
  assign src_wall_x = erase ? prev_wall_x : new_wall_x_nxt;
  assign src_gap_y  = erase ? prev_gap_y  : new_gap_y_nxt;

  // Pixel that the output registers will present in the next cycle.
  always_comb begin
    pixel_state = 1'b0;
    in_gap      = 1'b0;
    pix_x9      = '0;
    pix_y9      = '0;
    gap_lo9     = '0;
    pix_col     = BG_COLOUR;
    case (state_nxt)
      S_ERASE_BIRD, S_DRAW_BIRD: begin
        pixel_state = 1'b1;
        pix_x9      = BIRD_X9 + {2'b00, cx_nxt};
        pix_y9      = {2'b00, src_bird_y} + {2'b00, cy_nxt};
        pix_col     = erase ? BG_COLOUR : BIRD_COLOUR;
      end
      S_ERASE_WALL, S_DRAW_WALL: begin
        pixel_state = 1'b1;
        pix_x9      = {1'b0, src_wall_x} + {2'b00, cx_nxt};
        pix_y9      = {2'b00, cy_nxt};
        gap_lo9     = {2'b00, src_gap_y};
        in_gap      = (pix_y9 >= gap_lo9) && (pix_y9 < gap_lo9 + GAP_H9);
        pix_col     = erase ? BG_COLOUR : WALL_COLOUR;
      end
      default: ;
    endcase
    pix_plot = pixel_state && !in_gap && (pix_x9 < SCREEN_W9) && (pix_y9 < SCREEN_H9);
  end

  // Output registers; coordinates and colour hold outside the pixel states.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q    <= '0;
      y_q    <= '0;
      col_q  <= '0;
      plot_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      plot_q <= pix_plot;
      busy_q <= pixel_state;
      done_q <= (state_nxt == S_DONE);
      if (pixel_state) begin
        x_q   <= pix_x9[7:0];
        y_q   <= pix_y9[6:0];
        col_q <= pix_col;
      end
    end
  end

  // Position bookkeeping: new_* captured on start, promoted to prev_* in DONE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      new_bird_y  <= '0;
      new_wall_x  <= '0;
      new_gap_y   <= '0;
      prev_bird_y <= '0;
      prev_wall_x <= '0;
      prev_gap_y  <= '0;
      prev_valid  <= 1'b0;
    end else begin
      new_bird_y <= new_bird_y_nxt;
      new_wall_x <= new_wall_x_nxt;
      new_gap_y  <= new_gap_y_nxt;
      if (state == S_DONE) begin
        prev_bird_y <= new_bird_y;
        prev_wall_x <= new_wall_x;
        prev_gap_y  <= new_gap_y;
        prev_valid  <= 1'b1;
      end
    end
  end

  assign bus.x_out      = x_q;
  assign bus.y_out      = y_q;
  assign bus.colour_out = col_q;
  assign bus.plot       = plot_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
